// File: rtl/sync_fifo_fwft_stream_reader.sv
// Read-side drain for an FWFT FIFO: pops words into a two-entry skid buffer,
// presents them on a registered valid/ready stream, frames fixed-length
// packets with o_last and counts completed packets.
//
// Stream handshake: a beat transfers at a rising edge where o_valid and
// i_ready are both 1. While o_valid=1 and i_ready=0, o_data and o_last hold.
// Only i_clr or rst can drop o_valid without a transfer.
module sync_fifo_fwft_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic [15:0]           o_pkt_count
);

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    // Buffer occupancy doubles as the state of the skid controller.
    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t                  occ, occ_nxt;
    logic [DATA_WIDTH-1:0] out_reg, out_nxt;
    logic [DATA_WIDTH-1:0] skid_reg, skid_nxt;
    logic [BW-1:0]         beat_cnt, beat_nxt;
    logic [15:0]           pkt_cnt, pkt_nxt;
    logic                  pop;
    logic                  hs;

    // Pop decision never looks at i_ready, so rd_en has no combinational
    // path from the downstream consumer.
    assign pop          = !i_fifo_empty && !i_clr && (occ != OCC_2);
    assign o_fifo_rd_en = pop && !rst;
    assign o_valid      = (occ != OCC_0);
    assign hs           = o_valid && i_ready;
    assign o_data       = out_reg;
    assign o_last       = o_valid && (beat_cnt == LAST_BEAT);
    assign o_pkt_count  = pkt_cnt;

    // Next occupancy and buffer contents; clear empties the buffer.
    always_comb begin
        occ_nxt  = occ;
        out_nxt  = out_reg;
        skid_nxt = skid_reg;
        if (i_clr) begin
            occ_nxt = OCC_0;
        end else begin
            case (occ)
                OCC_0: begin
                    if (pop) begin
                        out_nxt = i_fifo_rd_data;
                        occ_nxt = OCC_1;
                    end
                end
                OCC_1: begin
                    if (pop && hs) begin
                        out_nxt = i_fifo_rd_data;
                    end else if (pop) begin
                        skid_nxt = i_fifo_rd_data;
                        occ_nxt  = OCC_2;
                    end else if (hs) begin
                        occ_nxt = OCC_0;
                    end
                end
                OCC_2: begin
                    if (hs) begin
                        out_nxt = skid_reg;
                        occ_nxt = OCC_1;
                    end
                end
                default: occ_nxt = OCC_0;
            endcase
        end
    end

    // Packet framing counters; a handshake coinciding with clear is dropped.
    always_comb begin
        beat_nxt = beat_cnt;
        pkt_nxt  = pkt_cnt;
        if (i_clr) begin
            beat_nxt = '0;
            pkt_nxt  = '0;
        end else if (hs) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_nxt = '0;
                pkt_nxt  = pkt_cnt + 16'd1;
            end else begin
                beat_nxt = beat_cnt + BW'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= OCC_0;
            out_reg  <= '0;
            skid_reg <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            occ      <= occ_nxt;
            out_reg  <= out_nxt;
            skid_reg <= skid_nxt;
            beat_cnt <= beat_nxt;
            pkt_cnt  <= pkt_nxt;
        end
    end

endmodule

// File: doc/sync_fifo_fwft_stream_reader.md
# sync_fifo_fwft_stream_reader

Read-side companion for the team's synchronous first-word-fall-through (FWFT) FIFO with clear. It drains the FIFO through its read interface (`empty`, `rd_data`, `rd_en`) and presents the words on a registered valid/ready stream. A two-entry skid buffer decouples the FIFO's `rd_en` from downstream `i_ready`. The block also frames the stream into fixed-length packets (`o_last`) and counts completed packets. It sits between the FIFO and any stream consumer; the same `i_clr` that clears the FIFO also clears this block.

## Interface
- `DATA_WIDTH`, default 8: width of the FIFO word and of `o_data`.
- `PKT_LEN`, default 4: beats per packet, at least 1. `o_last` marks every `PKT_LEN`-th accepted beat.
- `clk`  input  1  clock; everything is on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `i_clr`  input  1  synchronous flush; drive it with the FIFO's own `i_clr`.
- `i_fifo_empty`  input  1  FIFO `o_empty`.
- `i_fifo_rd_data`  input  `DATA_WIDTH`  FIFO `o_rd_data`; valid in the same cycle that `i_fifo_empty` is 0 (FWFT).
- `o_fifo_rd_en`  output  1  FIFO `i_rd_en`; a pop happens at the edge where it is 1.
- `o_valid`  output  1  stream valid.
- `o_data`  output  `DATA_WIDTH`  stream data.
- `o_last`  output  1  last beat of a packet; qualified by `o_valid`.
- `i_ready`  input  1  stream ready.
- `o_pkt_count`  output  16  number of completed packets; wraps modulo 2^16.

## Operation
- Storage is `out_reg` (oldest word, drives `o_data`) and `skid_reg`. `occ` (0..2) is the number of valid entries. `o_valid` = (`occ` != 0).
- `pop` = `o_fifo_rd_en` = !`i_fifo_empty` && !`i_clr` && (`occ` < 2). It does not depend on `i_ready`.
- `hs` = `o_valid` && `i_ready`.
- Next-state rules when `i_clr` = 0:
  - `occ`=0, `pop`: `out_reg` <- `i_fifo_rd_data`; `occ`=1.
  - `occ`=1, `pop` and `hs`: `out_reg` <- `i_fifo_rd_data`; `occ` stays 1.
  - `occ`=1, `pop` and no `hs`: `skid_reg` <- `i_fifo_rd_data`; `occ`=2.
  - `occ`=1, `hs` and no `pop`: `occ`=0.
  - `occ`=2, `hs`: `out_reg` <- `skid_reg`; `occ`=1. No pop is possible in this state.
  - Otherwise: hold.
- Stream rule: while `o_valid`=1 and `i_ready`=0, `o_data` and `o_last` hold stable. Only `i_clr` or `rst` may drop `o_valid` without a handshake.
- `beat_cnt` has width clog2(`PKT_LEN`), minimum 1. It increments on each `hs` and wraps from `PKT_LEN`-1 to 0.
- `o_last` = `o_valid` && (`beat_cnt` == `PKT_LEN`-1). With `PKT_LEN`=1, every beat is last.
- `o_pkt_count` increments on `hs` && `o_last`, and wraps from 0xFFFF to 0.
- `i_clr` = 1:
  - `o_fifo_rd_en` is forced to 0.
  - `occ`, `beat_cnt` and `o_pkt_count` go to 0 at the edge.
  - A handshake in the same cycle is discarded: clear wins and the counters do not increment.
- Word order is strict FIFO order. No word is duplicated or dropped, except by clear.

## Timing
- Reset values: `o_valid`=0, `o_last`=0, `o_fifo_rd_en`=0, `o_pkt_count`=0, `o_data`=0, `occ`=0, `beat_cnt`=0.
- `rst` asserted mid-operation empties the buffer immediately (asynchronously). Words already popped from the FIFO are lost; the system resets the FIFO together with this block.
- Latency: a word popped at edge N appears on `o_data` with `o_valid`=1 at edge N. It is visible one cycle after the FIFO presents it, when `occ`=0.
- Throughput: one beat per cycle while the FIFO is non-empty and `i_ready`=1. The steady state is `occ`=1 with `pop` and `hs` every cycle.
- Backpressure: at most 2 words are popped after `i_ready` falls. `o_fifo_rd_en` drops in the cycle after `occ` reaches 2.
- After `i_clr` at edge N: `o_valid`=0 and `o_pkt_count`=0 from N. Popping can resume in cycle N+1 if the FIFO is non-empty. The FIFO itself is also empty after a clear.

## Test plan
- Reset, then FIFO empty with `i_ready`=1 -> `o_valid`=0 and `o_fifo_rd_en`=0 for all cycles.
- FIFO holds 0x01..0x08, `i_ready`=1, `PKT_LEN`=4 -> `o_data` is 0x01..0x08 on 8 consecutive cycles, the first one cycle after the first `rd_en`. `o_last`=1 on 0x04 and 0x08. `o_pkt_count` ends at 2.
- Same data, `i_ready` held 0 -> exactly 2 pops (`occ`=2), `o_data`=0x01 stable. Release `i_ready` -> 0x01..0x08 in order with no gaps or duplicates.
- `i_ready` toggling pseudo-randomly against a random FIFO fill -> a scoreboard sees in-order, lossless data. `o_data` never changes while `o_valid` && !`i_ready`.
- `i_clr` pulsed while `occ`=2, `beat_cnt`=2 and `i_ready`=1 -> next cycle `o_valid`=0, `o_pkt_count`=0, no `rd_en` during the clear. The next packet's `o_last` lands on its 4th beat.
- `o_pkt_count` preloaded by running 65536 packets with `PKT_LEN`=1 -> wraps to 0. `rst` asserted mid-stream -> all outputs return to their reset values immediately.
